// File: rtl/axi_image_loader_ctrl.sv
// AXI4-Lite write-side loader for the SNN input image buffer.
// Pixel writes fill the buffer; a start write at CTRL_ADDR streams the image
// to the core over valid/ready and locks the buffer until infer_done.
// Optional macro IRQ_EN adds a sticky done interrupt (irq), cleared by a
// control write with WDATA[1]=1.
//
// state    | meaning
// W_IDLE   | collecting AW and W beats into their holding registers
// W_RESP   | write committed, presenting BRESP until BREADY
// S_IDLE   | buffer writable, waiting for a start command
// S_STREAM | presenting buf[cnt] on the pixel stream
// S_WAIT   | image sent, buffer locked until infer_done
module axi_image_loader_ctrl #(
   parameter int unsigned N_PIXELS  = 256,
   parameter int unsigned PIXEL_W   = 8,
   parameter logic [31:0] CTRL_ADDR = 32'h0000_2000
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   input  logic [31:0]        AWADDR,
   input  logic [2:0]         AWPROT,
   input  logic               AWVALID,
   output logic               AWREADY,
   input  logic [31:0]        WDATA,
   input  logic [3:0]         WSTRB,
   input  logic               WVALID,
   output logic               WREADY,
   output logic [1:0]         BRESP,
   output logic               BVALID,
   input  logic               BREADY,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [PIXEL_W-1:0] pix_data,
   output logic [7:0]         pix_idx,
   output logic               pix_last,
   input  logic               infer_done,
`ifdef IRQ_EN
   output logic               irq,
`endif
   output logic               busy
);

   localparam int unsigned IDX_W   = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
   localparam logic [31:0] PIX_END = 32'(N_PIXELS * 32);
   localparam logic [1:0]  OKAY    = 2'b00;
   localparam logic [1:0]  SLVERR  = 2'b10;
   localparam logic [1:0]  DECERR  = 2'b11;

   typedef enum logic       {W_IDLE, W_RESP} w_state_t;
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} s_state_t;

   w_state_t            w_state_q, w_state_d;
   s_state_t            s_state_q, s_state_d;
   logic                aw_full_q, aw_full_d;
   logic                w_full_q, w_full_d;
   logic [31:0]         awaddr_q, awaddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                wstrb0_q, wstrb0_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [PIXEL_W-1:0]  buf_q [N_PIXELS];
   logic                irq_q, irq_d;

   logic                aw_hs, w_hs, commit, is_ctrl, is_pix, busy_now;
   logic                pix_we, start, pix_hs, cnt_last;
   logic [31:0]         cur_addr, cur_data;
   logic                cur_strb0;
   logic [1:0]          resp;
   logic [IDX_W-1:0]    wr_idx;
   logic                unused_bits;

   assign unused_bits = ^{AWPROT, AWADDR, WDATA, WSTRB, wdata_q};

   assign AWREADY   = (w_state_q == W_IDLE) && !aw_full_q;
   assign WREADY    = (w_state_q == W_IDLE) && !w_full_q;
   assign BVALID    = (w_state_q == W_RESP);
   assign BRESP     = bresp_q;
   assign busy_now  = (s_state_q != S_IDLE);
   assign busy      = busy_now;
   assign pix_valid = (s_state_q == S_STREAM);
   assign pix_data  = pix_valid ? buf_q[cnt_q] : '0;
   assign pix_idx   = 8'(cnt_q);
   assign cnt_last  = (cnt_q == IDX_W'(N_PIXELS - 1));
   assign pix_last  = pix_valid && cnt_last;
   assign pix_hs    = pix_valid && pix_ready;

   // Merge live channel beats with held ones and decode the pending write.
   always_comb begin
      aw_hs     = AWVALID && AWREADY;
      w_hs      = WVALID && WREADY;
      cur_addr  = aw_full_q ? awaddr_q : AWADDR;
      cur_data  = w_full_q ? wdata_q : WDATA;
      cur_strb0 = w_full_q ? wstrb0_q : WSTRB[0];
      commit    = (w_state_q == W_IDLE) && (aw_full_q || aw_hs) && (w_full_q || w_hs);
      is_ctrl   = (cur_addr == CTRL_ADDR);
      is_pix    = !is_ctrl && (cur_addr < PIX_END);
      wr_idx    = cur_addr[IDX_W+4:5];
      pix_we    = commit && is_pix && !busy_now && cur_strb0;
      start     = commit && is_ctrl && cur_data[0] && !busy_now;
      resp      = DECERR;
      if (is_ctrl) begin
         resp = (cur_data[0] && busy_now) ? SLVERR : OKAY;
`ifdef IRQ_EN
         if (cur_data[1]) resp = OKAY;
`endif
      end else if (is_pix) begin
         resp = busy_now ? SLVERR : OKAY;
      end
   end

   // Write channel FSM: hold AW/W independently, commit once both are present.
   always_comb begin
      w_state_d = w_state_q;
      aw_full_d = aw_full_q;
      w_full_d  = w_full_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb0_d  = wstrb0_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: begin
            if (commit) begin
               w_state_d = W_RESP;
               aw_full_d = 1'b0;
               w_full_d  = 1'b0;
               bresp_d   = resp;
            end else begin
               if (aw_hs) begin
                  aw_full_d = 1'b1;
                  awaddr_d  = AWADDR;
               end
               if (w_hs) begin
                  w_full_d = 1'b1;
                  wdata_d  = WDATA;
                  wstrb0_d = WSTRB[0];
               end
            end
         end
         W_RESP: if (BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Stream FSM: walk the buffer, then wait for the core to finish.
   always_comb begin
      s_state_d = s_state_q;
      cnt_d     = cnt_q;
      irq_d     = irq_q;
      case (s_state_q)
         S_IDLE: if (start) begin
            s_state_d = S_STREAM;
            cnt_d     = '0;
         end
         S_STREAM: if (pix_hs) begin
            if (cnt_last) begin
               s_state_d = S_WAIT;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: if (infer_done) s_state_d = S_IDLE;
         default: s_state_d = S_IDLE;
      endcase
`ifdef IRQ_EN
      // Set is evaluated last so it wins over a same-edge clear.
      if (commit && is_ctrl && cur_data[1]) irq_d = 1'b0;
      if ((s_state_q == S_WAIT) && infer_done) irq_d = 1'b1;
`endif
   end

`ifdef IRQ_EN
   assign irq = irq_q;
`endif

   // Control state registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state_q <= W_IDLE;
         s_state_q <= S_IDLE;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb0_q  <= 1'b0;
         bresp_q   <= OKAY;
         cnt_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         s_state_q <= s_state_d;
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb0_q  <= wstrb0_d;
         bresp_q   <= bresp_d;
         cnt_q     <= cnt_d;
         irq_q     <= irq_d;
      end
   end

   // Image buffer; cleared by reset so a restarted stream never sees stale pixels.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < N_PIXELS; i++) buf_q[i] <= '0;
      end else if (pix_we) begin
         buf_q[wr_idx] <= cur_data[PIXEL_W-1:0];
      end
   end

endmodule

// File: tb/tb_axi_image_loader_ctrl.sv
// Scoreboard bench for axi_image_loader_ctrl: expected write responses and
// pixels are queued by the stimulus, a negedge monitor pops and compares.
module tb_axi_image_loader_ctrl;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] AWADDR = '0;
   logic [2:0]  AWPROT = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic [7:0]  pix_data;
   logic [7:0]  pix_idx;
   logic        pix_last;
   logic        infer_done = 1'b0;
   logic        busy;

   axi_image_loader_ctrl dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_idx(pix_idx), .pix_last(pix_last), .infer_done(infer_done), .busy(busy)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [7:0] idx;
      logic [7:0] data;
      logic       last;
   } pix_t;

   pix_t       pix_q[$];
   logic [1:0] b_q[$];
   logic [7:0] model[256];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout expected completion", name);
   endtask

   // Monitor: pops scoreboard entries on each handshake and checks stall stability.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_idx, prev_data;
      pix_t       e;
      prev_stall = 1'b0;
      prev_idx   = '0;
      prev_data  = '0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            prev_stall = 1'b0;
         end else begin
            if (BVALID && BREADY) begin
               if (b_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL bresp_unexpected: got %0h expected no response", BRESP);
               end else begin
                  chk("bresp", 32'(BRESP), 32'(b_q.pop_front()));
               end
            end
            if (prev_stall) begin
               chk("stall_valid", 32'(pix_valid), 32'd1);
               chk("stall_idx", 32'(pix_idx), 32'(prev_idx));
               chk("stall_data", 32'(pix_data), 32'(prev_data));
            end
            if (pix_valid && pix_ready) begin
               if (pix_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL pix_unexpected: got idx %0d expected no pixel", pix_idx);
               end else begin
                  e = pix_q.pop_front();
                  chk("pix_idx", 32'(pix_idx), 32'(e.idx));
                  chk("pix_data", 32'(pix_data), 32'(e.data));
                  chk("pix_last", 32'(pix_last), 32'(e.last));
               end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_idx   = pix_idx;
            prev_data  = pix_data;
         end
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Same-cycle AW+W write with BREADY high; optional infer_done on the accept cycle.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp,
                            input logic with_done);
      int   t;
      logic aw_ok, w_ok, aw_now, w_now;
      b_q.push_back(exp);
      AWADDR = addr; WDATA = data; WSTRB = strb;
      AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
      infer_done = with_done;
      aw_ok = 1'b0; w_ok = 1'b0; t = 0;
      while (!(aw_ok && w_ok) && t < 50) begin
         aw_now = AWVALID && AWREADY;
         w_now  = WVALID && WREADY;
         tick();
         infer_done = 1'b0;
         if (aw_now) begin aw_ok = 1'b1; AWVALID = 1'b0; end
         if (w_now)  begin w_ok  = 1'b1; WVALID  = 1'b0; end
         t++;
      end
      AWVALID = 1'b0; WVALID = 1'b0;
      if (!(aw_ok && w_ok)) fail_now("write_accept");
      chk("bvalid_latency", 32'(BVALID), 32'd1);
      t = 0;
      while (BVALID && t < 50) begin tick(); t++; end
      if (t >= 50) fail_now("write_resp");
   endtask

   task automatic push_stream();
      pix_t e;
      for (int i = 0; i < 256; i++) begin
         e.idx  = 8'(i);
         e.data = model[i];
         e.last = (i == 255);
         pix_q.push_back(e);
      end
   endtask

   task automatic run_stream(input logic toggle);
      int t;
      t = 0;
      while (!(busy && !pix_valid) && t < 3000) begin
         pix_ready = toggle ? ~pix_ready : 1'b1;
         tick();
         t++;
      end
      pix_ready = 1'b0;
      chk("stream_to_wait", 32'(busy && !pix_valid), 32'd1);
   endtask

   task automatic pulse_done();
      infer_done = 1'b1;
      tick();
      infer_done = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awready"}, 32'(AWREADY), 32'd1);
      chk({tag, "_wready"}, 32'(WREADY), 32'd1);
      chk({tag, "_bvalid"}, 32'(BVALID), 32'd0);
      chk({tag, "_bresp"}, 32'(BRESP), 32'd0);
      chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      chk({tag, "_pix_idx"}, 32'(pix_idx), 32'd0);
      chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
      chk({tag, "_pix_last"}, 32'(pix_last), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      for (int i = 0; i < 256; i++) model[i] = '0;
      repeat (3) @(posedge ACLK);
      #1;
      chk_reset_outputs("reset");
      ARESETN = 1'b1;
      tick();

      // Fill every pixel with its index.
      for (int i = 0; i < 256; i++) begin
         axi_write(32'(i * 32), 32'(i), 4'h1, 2'b00, 1'b0);
         model[i] = 8'(i);
      end

      // Same-cycle AW/W to pixel 1.
      axi_write(32'h0000_0020, 32'h0000_00A5, 4'hF, 2'b00, 1'b0);
      model[1] = 8'hA5;

      // W three cycles ahead of AW, response held off by BREADY for 4 cycles.
      b_q.push_back(2'b00);
      BREADY = 1'b0;
      WDATA = 32'h0000_003C; WSTRB = 4'h1; WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
      chk("wready_held", 32'(WREADY), 32'd0);
      tick();
      tick();
      chk("wfirst_awready", 32'(AWREADY), 32'd1);
      chk("wfirst_no_bvalid", 32'(BVALID), 32'd0);
      AWADDR = 32'h0000_0040; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bvalid_hold", 32'(BVALID), 32'd1);
         chk("bresp_hold", 32'(BRESP), 32'd0);
         tick();
      end
      BREADY = 1'b1;
      tick();
      chk("bvalid_cleared", 32'(BVALID), 32'd0);
      chk("ready_restored", 32'(AWREADY && WREADY), 32'd1);
      model[2] = 8'h3C;

      // Unmapped address, masked strobe, control no-op.
      axi_write(32'h0000_3000, 32'h0000_00FF, 4'hF, 2'b11, 1'b0);
      axi_write(32'h0000_0060, 32'h0000_00EE, 4'b1110, 2'b00, 1'b0);
      axi_write(32'h0000_2000, 32'h0000_0000, 4'hF, 2'b00, 1'b0);
      chk("noop_busy", 32'(busy), 32'd0);

      // First stream with pix_ready toggling.
      push_stream();
      axi_write(32'h0000_2000, 32'h0000_0001, 4'hF, 2'b00, 1'b0);
      chk("start_busy", 32'(busy), 32'd1);
      run_stream(1'b1);

      // Writes while locked; the start lands on the same edge as infer_done.
      axi_write(32'h0000_0000, 32'h0000_0077, 4'hF, 2'b10, 1'b0);
      axi_write(32'h0000_2000, 32'h0000_0001, 4'hF, 2'b10, 1'b1);
      chk("done_busy", 32'(busy), 32'd0);
      tick();
      tick();
      chk("no_restart", 32'(pix_valid), 32'd0);
      pulse_done();
      chk("idle_done_ignored", 32'(busy), 32'd0);

      // Restart succeeds; buf[0] must still be 0.
      push_stream();
      axi_write(32'h0000_2000, 32'h0000_0001, 4'hF, 2'b00, 1'b0);
      run_stream(1'b0);
      pulse_done();
      chk("second_done_busy", 32'(busy), 32'd0);

      // Reset while pixel 100 is presented.
      push_stream();
      axi_write(32'h0000_2000, 32'h0000_0001, 4'hF, 2'b00, 1'b0);
      pix_ready = 1'b1;
      t = 0;
      while (!(pix_valid && pix_idx == 8'd100) && t < 500) begin tick(); t++; end
      chk("reached_pix100", 32'(pix_idx), 32'd100);
      ARESETN = 1'b0;
      pix_ready = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      pix_q.delete();
      tick();
      ARESETN = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) model[i] = '0;
      push_stream();
      axi_write(32'h0000_2000, 32'h0000_0001, 4'hF, 2'b00, 1'b0);
      run_stream(1'b0);
      pulse_done();
      chk("final_busy", 32'(busy), 32'd0);

      tick();
      chk("pix_queue_drained", 32'(pix_q.size()), 32'd0);
      chk("b_queue_drained", 32'(b_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
